div_clk_monitor: RTL and testbench

//  Downstream checker for the programmable counter-based frequency divider.

---
 rtl/div_clk_monitor_if.sv | 41 ++++
 rtl/div_clk_monitor.sv | 190 +++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/div_clk_monitor_if.sv
// ---------------------------------------------------------------------------
// div_clk_monitor_if
//   Bundles the request/result signals of the divider monitor so the monitor
//   and whatever drives it (self-test controller or bench) share one port.
//
//   start     1-cycle request to begin a measurement
//   m_exp     divider ratio M under test, latched on an accepted start
//   div_in    divider output being checked
//   busy      measurement in progress
//   done      1-cycle pulse, result fields valid
//   period    last measured period in clk cycles
//   high_time clk cycles div_in was high in the last measured period
//   pass      1 = every checked period matched the expected one
//   err_code  0 ok, 1 mismatch, 2 timeout, 3 bypass
//
//   master: drives start/m_exp/div_in, observes the results
//   slave : the monitor itself
// ---------------------------------------------------------------------------
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [2:0]       m_exp;
  logic             div_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             pass;
  logic [1:0]       err_code;

  modport master (
    output start, m_exp, div_in,
    input  busy, done, period, high_time, pass, err_code
  );

  modport slave (
    input  start, m_exp, div_in,
    output busy, done, period, high_time, pass, err_code
  );
endinterface

// File: rtl/div_clk_monitor.sv
// ---------------------------------------------------------------------------
// div_clk_monitor
//   Checker for the programmable counter-based frequency divider. Samples the
//   divider output in the clk domain, measures NUM_PER consecutive periods and
//   the high time of each, and compares every period with the one expected for
//   the latched ratio M (M=0 means 8, since the divider's down-counter wraps
//   to 7). The verdict is presented with a one-cycle done pulse and held until
//   the next accepted start.
//
//   clk   system clock, same clock that drives the divider
//   reset asynchronous, active-high
//   mon   slave side of div_clk_monitor_if (start, m_exp, div_in in;
//         busy, done, period, high_time, pass, err_code out)
//
//   Parameters: CNT_W counter width, NUM_PER periods per measurement,
//   TO_CYC max clk cycles between rising edges before a timeout.
// ---------------------------------------------------------------------------
module div_clk_monitor #(
  parameter int CNT_W   = 8,
  parameter int NUM_PER = 4,
  parameter int TO_CYC  = 64
) (
  input logic              clk,
  input logic              reset,
  div_clk_monitor_if.slave mon
);

  localparam int IDX_W = $clog2(NUM_PER + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TO_CYC);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] PER_LIM = IDX_W'(NUM_PER);

  typedef enum logic [1:0] {IDLE, SYNC, MEAS, REPORT} state_t;

  state_t           state, state_n;
  logic [2:0]       m_lat, m_lat_n;
  logic             div_q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hi, hi_n;
  logic [CNT_W-1:0] to_cnt, to_cnt_n;
  logic [IDX_W-1:0] per_idx, per_idx_n;
  logic             mism, mism_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic [CNT_W-1:0] high_q, high_n;
  logic             pass_q, pass_n;
  logic [1:0]       err_q, err_n;

  logic             rise;
  logic [CNT_W-1:0] exp_p;
  logic [CNT_W-1:0] to_inc;
  logic [IDX_W-1:0] idx_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign rise    = mon.div_in & ~div_q;
  assign exp_p   = (m_lat == 3'd0) ? CNT_W'(8) : CNT_W'(m_lat);
  assign to_inc  = sat_inc(to_cnt);
  assign idx_inc = per_idx + IDX_ONE;

  // Next-state and datapath decisions. The rising-edge cycle itself counts as
  // cycle 1 of the new period, hence cnt/hi restart at 1. A timeout fires on
  // the edge where to_cnt would reach TO_CYC.
  always_comb begin
    state_n   = state;
    m_lat_n   = m_lat;
    cnt_n     = cnt;
    hi_n      = hi;
    to_cnt_n  = to_cnt;
    per_idx_n = per_idx;
    mism_n    = mism;
    period_n  = period_q;
    high_n    = high_q;
    pass_n    = pass_q;
    err_n     = err_q;

    case (state)
      IDLE: begin
        if (mon.start) begin
          m_lat_n   = mon.m_exp;
          pass_n    = 1'b0;
          err_n     = 2'd0;
          period_n  = '0;
          high_n    = '0;
          cnt_n     = '0;
          hi_n      = '0;
          to_cnt_n  = '0;
          per_idx_n = '0;
          mism_n    = 1'b0;
          // M=1 makes out_clk equal to clk, which cannot be sampled here.
          if (mon.m_exp == 3'd1) begin
            state_n = REPORT;
            err_n   = 2'd3;
            pass_n  = 1'b1;
          end else begin
            state_n = SYNC;
          end
        end
      end

      SYNC: begin
        if (rise) begin
          state_n   = MEAS;
          cnt_n     = CNT_ONE;
          hi_n      = CNT_ONE;
          per_idx_n = '0;
          to_cnt_n  = '0;
        end else if (to_inc == TO_LIM) begin
          state_n = REPORT;
          err_n   = 2'd2;
          pass_n  = 1'b0;
        end else begin
          to_cnt_n = to_inc;
        end
      end

      MEAS: begin
        if (rise) begin
          period_n  = cnt;
          high_n    = hi;
          cnt_n     = CNT_ONE;
          hi_n      = CNT_ONE;
          to_cnt_n  = '0;
          per_idx_n = idx_inc;
          mism_n    = mism | (cnt != exp_p);
          if (idx_inc == PER_LIM) begin
            state_n = REPORT;
            err_n   = mism_n ? 2'd1 : 2'd0;
            pass_n  = ~mism_n;
          end
        end else if (to_inc == TO_LIM) begin
          state_n = REPORT;
          err_n   = 2'd2;
          pass_n  = 1'b0;
        end else begin
          cnt_n    = sat_inc(cnt);
          hi_n     = mon.div_in ? sat_inc(hi) : hi;
          to_cnt_n = to_inc;
        end
      end

      REPORT: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // State, counters and held results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      m_lat    <= '0;
      div_q    <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      to_cnt   <= '0;
      per_idx  <= '0;
      mism     <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      pass_q   <= 1'b0;
      err_q    <= 2'd0;
    end else begin
      state    <= state_n;
      m_lat    <= m_lat_n;
      div_q    <= mon.div_in;
      cnt      <= cnt_n;
      hi       <= hi_n;
      to_cnt   <= to_cnt_n;
      per_idx  <= per_idx_n;
      mism     <= mism_n;
      period_q <= period_n;
      high_q   <= high_n;
      pass_q   <= pass_n;
      err_q    <= err_n;
    end
  end

  assign mon.busy      = (state == SYNC) || (state == MEAS);
  assign mon.done      = (state == REPORT);
  assign mon.period    = period_q;
  assign mon.high_time = high_q;
  assign mon.pass      = pass_q;
  assign mon.err_code  = err_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_div_clk_monitor
//   Directed bench for div_clk_monitor. A behavioural divider model produces
//   div_in (one-cycle-high pulse every M cycles, M=0 meaning 8). Inputs change
//   and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_div_clk_monitor;

  localparam int CNT_W = 8;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  div_clk_monitor_if #(.CNT_W(CNT_W)) ifc ();

  div_clk_monitor #(
    .CNT_W  (CNT_W),
    .NUM_PER(4),
    .TO_CYC (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: down-counter reloaded with M-1 (wrapping to 7 for M=0),
  // output high for the single cycle where the counter is zero.
  logic       div_en;
  logic [2:0] div_m;
  logic [2:0] div_cnt;

  always @(negedge clk) begin
    if (!div_en) begin
      div_cnt    = 3'd0;
      ifc.div_in = 1'b0;
    end else begin
      ifc.div_in = (div_cnt == 3'd0);
      div_cnt    = (div_cnt == 3'd0) ? div_m - 3'd1 : div_cnt - 3'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Pulse start for one cycle; returns on the falling edge right after the
  // rising edge that samples it.
  task automatic applyStimulus(input logic [2:0] m);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.m_exp = m;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // lat = number of rising edges from the accepting edge up to the one that
  // raised done (1 = done visible right after the accepting edge).
  task automatic waitDone(input string tag, input int start_lat, output int lat);
    lat = start_lat;
    while (!ifc.done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    checkOutput(tag, 32'(ifc.done), 32'd1);
  endtask

  task automatic runDivider(input logic [2:0] m);
    div_m  = m;
    div_en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic checkResult(input string tag, input int per, input int hi,
                             input int ps, input int ec);
    checkOutput({tag, "_period"}, 32'(ifc.period), 32'(per));
    checkOutput({tag, "_high"}, 32'(ifc.high_time), 32'(hi));
    checkOutput({tag, "_pass"}, 32'(ifc.pass), 32'(ps));
    checkOutput({tag, "_err"}, 32'(ifc.err_code), 32'(ec));
  endtask

  initial begin
    int lat;

    reset     = 1'b1;
    ifc.start = 1'b0;
    ifc.m_exp = 3'd0;
    div_en    = 1'b0;
    div_m     = 3'd3;
    repeat (3) @(negedge clk);

    checkOutput("rst_busy", 32'(ifc.busy), 32'd0);
    checkOutput("rst_done", 32'(ifc.done), 32'd0);
    checkResult("rst", 0, 0, 0, 0);
    reset = 1'b0;

    // 1: M=3 matched; a second start and m_exp change while busy are ignored.
    runDivider(3'd3);
    applyStimulus(3'd3);
    checkOutput("t1_busy", 32'(ifc.busy), 32'd1);
    ifc.start = 1'b1;
    ifc.m_exp = 3'd0;
    @(negedge clk);
    ifc.start = 1'b0;
    waitDone("t1_done", 2, lat);
    checkOutput("t1_busy_at_done", 32'(ifc.busy), 32'd0);
    checkResult("t1", 3, 1, 1, 0);
    @(negedge clk);
    checkOutput("t1_done_pulse", 32'(ifc.done), 32'd0);
    checkResult("t1_hold", 3, 1, 1, 0);

    // 2: M=0 is a divide-by-8.
    runDivider(3'd0);
    applyStimulus(3'd0);
    waitDone("t2_done", 1, lat);
    checkResult("t2", 8, 1, 1, 0);

    // 3: divider at 5 while 4 is expected.
    runDivider(3'd5);
    applyStimulus(3'd4);
    waitDone("t3_done", 1, lat);
    checkResult("t3", 5, 1, 0, 1);

    // 4: no edges at all -> timeout 64 cycles after entering SYNC.
    div_en = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(3'd6);
    waitDone("t4_done", 1, lat);
    checkOutput("t4_latency", 32'(lat - 1), 32'd64);
    checkResult("t4", 0, 0, 0, 2);

    // 5: M=1 bypass, done right after the accepting edge.
    applyStimulus(3'd1);
    waitDone("t5_done", 1, lat);
    checkOutput("t5_latency", 32'(lat), 32'd1);
    checkResult("t5", 0, 0, 1, 3);

    // 6: reset in the middle of a M=7 measurement, then a clean rerun.
    runDivider(3'd7);
    applyStimulus(3'd7);
    repeat (20) @(negedge clk);
    checkOutput("t6_pre_busy", 32'(ifc.busy), 32'd1);
    checkOutput("t6_pre_period", 32'(ifc.period), 32'd7);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_busy", 32'(ifc.busy), 32'd0);
    checkOutput("t6_rst_done", 32'(ifc.done), 32'd0);
    checkResult("t6_rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(3'd7);
    waitDone("t6_done", 1, lat);
    checkResult("t6", 7, 1, 1, 0);

    // 7: divider retimed from 3 to 6 mid-measurement -> mismatch, no abort.
    runDivider(3'd3);
    applyStimulus(3'd3);
    repeat (4) @(negedge clk);
    div_m = 3'd6;
    waitDone("t7_done", 5, lat);
    checkResult("t7", 6, 1, 0, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
